// File: rtl/iic_slave_regs.sv
// I2C target with byte-addressed register access: device/register address decode,
// write and read bursts with pointer auto-increment. SCL/SDA are oversampled on sysclk.
module iic_slave_regs #(
    parameter logic [6:0]  DEV_ADDR       = 7'h50,
    parameter int unsigned REG_ADDR_BYTES = 2,
    parameter int unsigned DATA_WIDTH     = 8
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  iic_scl,
    inout  logic                  iic_sda,
    output logic [15:0]           reg_addr,
    output logic                  reg_wr_en,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_rd_req,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  iic_busy,
    output logic                  iic_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ACK_DEV, S_REG_HI, S_REG_LO,
        S_WR_DATA, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    state_t                state_q,     state_d;
    logic [2:0]            bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  full_q,      full_d;
    logic                  ack_q,       ack_d;
    logic                  mack_q,      mack_d;
    logic                  rw_q,        rw_d;
    logic                  ptr_set_q,   ptr_set_d;
    logic                  matched_q,   matched_d;
    logic [7:0]            addr_hi_q,   addr_hi_d;
    logic [15:0]           reg_addr_q,  reg_addr_d;
    logic                  wr_en_q,     wr_en_d;
    logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic                  rd_req_q,    rd_req_d;
    logic                  rd_cap_q,    rd_cap_d;
    logic                  done_q,      done_d;
    logic                  sda_oe_q,    sda_oe_d;

    logic        scl_rise, scl_fall, start_c, stop_c;
    logic [15:0] next_addr;

    // Synchronizers track the bus even through reset so no false edge appears afterwards.
    always_ff @(posedge sysclk) begin
        scl_s1_q <= iic_scl;
        scl_s2_q <= scl_s1_q;
        scl_h_q  <= scl_s2_q;
        sda_s1_q <= iic_sda;
        sda_s2_q <= sda_s1_q;
        sda_h_q  <= sda_s2_q;
    end

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_c   = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
    assign stop_c    = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
    assign next_addr = (REG_ADDR_BYTES == 1) ? {8'h00, reg_addr_q[7:0] + 8'd1}
                                             : reg_addr_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        full_d     = full_q;
        ack_d      = ack_q;
        mack_d     = mack_q;
        rw_d       = rw_q;
        ptr_set_d  = ptr_set_q;
        matched_d  = matched_q;
        addr_hi_d  = addr_hi_q;
        reg_addr_d = reg_addr_q;
        wr_en_d    = 1'b0;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_cap_d   = rd_req_q;
        done_d     = 1'b0;
        sda_oe_d   = sda_oe_q;

        if (rd_cap_q) shift_d = reg_rd_data;

        if (stop_c) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            done_d    = matched_q;
            matched_d = 1'b0;
            ptr_set_d = 1'b0;
            full_d    = 1'b0;
            ack_d     = 1'b0;
            mack_d    = 1'b0;
        end else if (start_c) begin
            state_d   = S_DEV_ADDR;
            bit_cnt_d = '0;
            full_d    = 1'b0;
            ack_d     = 1'b0;
            mack_d    = 1'b0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                S_DEV_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
                    // Receive path: 8 rising edges fill the byte, then one ACK slot between falls.
                    if (scl_rise && !full_q && !ack_q) begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            full_d = 1'b1;
                            if (state_q == S_WR_DATA) begin
                                wr_en_d   = 1'b1;
                                wr_data_d = {shift_q[DATA_WIDTH-2:0], sda_s2_q};
                            end
                        end
                    end else if (scl_fall && full_q) begin
                        full_d = 1'b0;
                        if (state_q == S_DEV_ADDR) begin
                            if (shift_q[DATA_WIDTH-1:1] == DEV_ADDR && (!shift_q[0] || ptr_set_q)) begin
                                state_d   = S_ACK_DEV;
                                sda_oe_d  = 1'b1;
                                rw_d      = shift_q[0];
                                matched_d = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            ack_d    = 1'b1;
                            sda_oe_d = 1'b1;
                        end
                    end else if (scl_fall && ack_q) begin
                        ack_d     = 1'b0;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = '0;
                        if (state_q == S_REG_HI) begin
                            addr_hi_d = shift_q;
                            state_d   = S_REG_LO;
                        end else if (state_q == S_REG_LO) begin
                            reg_addr_d = (REG_ADDR_BYTES == 1) ? {8'h00, shift_q} : {addr_hi_q, shift_q};
                            ptr_set_d  = 1'b1;
                            state_d    = S_WR_DATA;
                        end else begin
                            reg_addr_d = next_addr;
                        end
                    end
                end
                S_ACK_DEV: begin
                    if (scl_rise && rw_q) rd_req_d = 1'b1;
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            state_d  = S_RD_DATA;
                            sda_oe_d = ~shift_q[DATA_WIDTH-1];
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = (REG_ADDR_BYTES == 1) ? S_REG_LO : S_REG_HI;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = S_RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            sda_oe_d  = ~shift_q[DATA_WIDTH-2];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2_q) begin
                            mack_d     = 1'b1;
                            reg_addr_d = next_addr;
                            rd_req_d   = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d   = 1'b0;
                        state_d  = S_RD_DATA;
                        sda_oe_d = ~shift_q[DATA_WIDTH-1];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            full_q     <= 1'b0;
            ack_q      <= 1'b0;
            mack_q     <= 1'b0;
            rw_q       <= 1'b0;
            ptr_set_q  <= 1'b0;
            matched_q  <= 1'b0;
            addr_hi_q  <= '0;
            reg_addr_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            rd_req_q   <= 1'b0;
            rd_cap_q   <= 1'b0;
            done_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            full_q     <= full_d;
            ack_q      <= ack_d;
            mack_q     <= mack_d;
            rw_q       <= rw_d;
            ptr_set_q  <= ptr_set_d;
            matched_q  <= matched_d;
            addr_hi_q  <= addr_hi_d;
            reg_addr_q <= reg_addr_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_cap_q   <= rd_cap_d;
            done_q     <= done_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign iic_sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_wr_data = wr_data_q;
    assign reg_rd_req  = rd_req_q;
    assign iic_busy    = (state_q != S_IDLE);
    assign iic_done    = done_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Directed bench: bit-banged I2C master on a pulled-up SDA line, two targets
// (2-byte and 1-byte register address) sharing the bus.
module tb_iic_slave_regs;

    localparam int unsigned Q = 31;  // quarter SCL period in sysclk cycles

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    logic iic_scl = 1'b1;
    logic m_sda  = 1'b1;
    wire  iic_sda;
    logic sda_line;

    pullup (iic_sda);
    assign iic_sda  = m_sda ? 1'bz : 1'b0;
    assign sda_line = (iic_sda === 1'b0) ? 1'b0 : 1'b1;

    logic [15:0] reg_addr, reg_addr2;
    logic        reg_wr_en, reg_wr_en2;
    logic [7:0]  reg_wr_data, reg_wr_data2;
    logic        reg_rd_req, reg_rd_req2;
    logic [7:0]  rd_data = '0, rd_data2 = '0;
    logic        iic_busy, iic_busy2;
    logic        iic_done, iic_done2;

    iic_slave_regs dut (
        .sysclk(sysclk), .rst(rst), .iic_scl(iic_scl), .iic_sda(iic_sda),
        .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
        .reg_rd_req(reg_rd_req), .reg_rd_data(rd_data),
        .iic_busy(iic_busy), .iic_done(iic_done)
    );

    iic_slave_regs #(.DEV_ADDR(7'h52), .REG_ADDR_BYTES(1), .DATA_WIDTH(8)) dut2 (
        .sysclk(sysclk), .rst(rst), .iic_scl(iic_scl), .iic_sda(iic_sda),
        .reg_addr(reg_addr2), .reg_wr_en(reg_wr_en2), .reg_wr_data(reg_wr_data2),
        .reg_rd_req(reg_rd_req2), .reg_rd_data(rd_data2),
        .iic_busy(iic_busy2), .iic_done(iic_done2)
    );

    always #10 sysclk = ~sysclk;

    // Register-file model: data = low address byte inverted, one cycle after the request.
    always @(posedge sysclk) begin
        if (reg_rd_req)  rd_data  <= reg_addr[7:0] ^ 8'hFF;
        if (reg_rd_req2) rd_data2 <= reg_addr2[7:0] ^ 8'hFF;
    end

    logic [15:0] wr_a[$], wr_a2[$];
    logic [7:0]  wr_d[$], wr_d2[$];
    int unsigned rd_cnt = 0, done_cnt = 0, done_cnt2 = 0;
    int unsigned dut_low = 0, viol = 0, since_fall = 0;
    logic        mon_en = 1'b1;
    logic        prev_line = 1'b1, prev_m = 1'b1, prev_scl = 1'b1;

    always @(negedge sysclk) begin
        if (reg_wr_en)  begin wr_a.push_back(reg_addr);   wr_d.push_back(reg_wr_data);   end
        if (reg_wr_en2) begin wr_a2.push_back(reg_addr2); wr_d2.push_back(reg_wr_data2); end
        if (reg_rd_req) rd_cnt++;
        if (iic_done)   done_cnt++;
        if (iic_done2)  done_cnt2++;
        if (sda_line == 1'b0 && m_sda == 1'b1) dut_low++;
        since_fall = (prev_scl && !iic_scl) ? 0 : since_fall + 1;
        // A line change without a master drive change comes from a target.
        if (mon_en && sda_line != prev_line && m_sda == prev_m && (iic_scl || since_fall < 3))
            viol++;
        prev_line = sda_line;
        prev_m    = m_sda;
        prev_scl  = iic_scl;
    end

    int unsigned errors = 0, checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input bit second, input int unsigned idx,
                          input logic [15:0] ea, input logic [7:0] ed);
        logic [23:0] got;
        if (!second) got = (wr_a.size() > idx)  ? {wr_a[idx],  wr_d[idx]}  : 24'hDEAD00;
        else         got = (wr_a2.size() > idx) ? {wr_a2[idx], wr_d2[idx]} : 24'hDEAD00;
        chk(tag, {8'h00, got}, {8'h00, ea, ed});
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge sysclk);
        #2;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        tick(Q); m_sda = b;
        tick(Q); iic_scl = 1'b1;
        tick(Q); r = sda_line;
        tick(Q); iic_scl = 1'b0;
    endtask

    task automatic i2c_start();
        if (iic_scl) begin
            tick(Q); m_sda = 1'b0;
            tick(Q); iic_scl = 1'b0;
        end else begin
            tick(Q); m_sda = 1'b1;
            tick(Q); iic_scl = 1'b1;
            tick(Q); m_sda = 1'b0;
            tick(Q); iic_scl = 1'b0;
        end
    endtask

    task automatic i2c_stop();
        tick(Q); m_sda = 1'b0;
        tick(Q); iic_scl = 1'b1;
        tick(Q); m_sda = 1'b1;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int unsigned i = 0; i < 8; i++) bit_xfer(b[7-i], r);
        bit_xfer(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic r;
        for (int unsigned i = 0; i < 8; i++) begin
            bit_xfer(1'b1, r);
            d[7-i] = r;
        end
        bit_xfer(mack, r);
    endtask

    task automatic clear_logs();
        wr_a.delete(); wr_d.delete(); wr_a2.delete(); wr_d2.delete();
        rd_cnt = 0; done_cnt = 0; done_cnt2 = 0; dut_low = 0;
    endtask

    initial begin
        logic       a;
        logic [3:0] acks;
        logic [7:0] d;

        tick(6);
        rst = 1'b0;
        tick(3);
        chk("rst_addr",  {16'h0, reg_addr}, 32'h0);
        chk("rst_busy",  {31'h0, iic_busy}, 32'h0);
        chk("rst_done",  {31'h0, iic_done}, 32'h0);
        chk("rst_wr",    {31'h0, reg_wr_en}, 32'h0);
        chk("rst_rdreq", {31'h0, reg_rd_req}, 32'h0);
        chk("rst_sda",   {31'h0, sda_line}, 32'h1);

        // Two-byte write burst
        clear_logs();
        i2c_start();
        write_byte(8'hA0, a); chk("w_ack_dev", {31'h0, a}, 32'h0);
        write_byte(8'h12, acks[0]);
        write_byte(8'h34, acks[1]);
        write_byte(8'h5A, acks[2]);
        write_byte(8'hC3, acks[3]);
        chk("w_acks", {28'h0, acks}, 32'h0);
        chk("w_busy", {31'h0, iic_busy}, 32'h1);
        i2c_stop();
        tick(8);
        chk("w_count", wr_a.size(), 32'd2);
        chk_wr("w_0", 1'b0, 0, 16'h1234, 8'h5A);
        chk_wr("w_1", 1'b0, 1, 16'h1235, 8'hC3);
        chk("w_done", done_cnt, 32'd1);
        chk("w_ptr", {16'h0, reg_addr}, 32'h1236);
        chk("w_idle", {31'h0, iic_busy}, 32'h0);

        // Random read of three bytes
        clear_logs();
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h10, acks[2]);
        i2c_start();
        write_byte(8'hA1, acks[3]);
        chk("r_acks", {28'h0, acks}, 32'h0);
        read_byte(d, 1'b0); chk("r_b0", {24'h0, d}, 32'hEF);
        read_byte(d, 1'b0); chk("r_b1", {24'h0, d}, 32'hEE);
        read_byte(d, 1'b1); chk("r_b2", {24'h0, d}, 32'hED);
        tick(8);
        chk("r_release", {31'h0, sda_line}, 32'h1);
        i2c_stop();
        tick(8);
        chk("r_rdreq", rd_cnt, 32'd3);
        chk("r_done", done_cnt, 32'd1);
        chk("r_nowr", wr_a.size(), 32'd0);

        // Address mismatch
        clear_logs();
        i2c_start();
        write_byte(8'hA2, acks[0]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h40, acks[2]);
        write_byte(8'h55, acks[3]);
        write_byte(8'hAA, a);
        chk("m_nacks", {27'h0, a, acks}, 32'h1F);
        chk("m_busy", {31'h0, iic_busy}, 32'h1);
        i2c_stop();
        tick(8);
        chk("m_busy_end", {31'h0, iic_busy}, 32'h0);
        chk("m_dut_low", dut_low, 32'd0);
        chk("m_activity", wr_a.size() + rd_cnt + done_cnt, 32'd0);

        // 16-bit pointer wrap
        clear_logs();
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'hFF, acks[1]);
        write_byte(8'hFF, acks[2]);
        write_byte(8'h11, acks[3]);
        write_byte(8'h22, a);
        i2c_stop();
        tick(8);
        chk("wr16_acks", {27'h0, a, acks}, 32'h0);
        chk_wr("wr16_0", 1'b0, 0, 16'hFFFF, 8'h11);
        chk_wr("wr16_1", 1'b0, 1, 16'h0000, 8'h22);

        // Aborts: STOP after 4 data bits, START after 3 data bits
        clear_logs();
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h20, acks[2]);
        for (int unsigned i = 0; i < 4; i++) bit_xfer(1'b0, a);
        i2c_stop();
        tick(8);
        chk("ab_stop_nowr", wr_a.size(), 32'd0);
        chk("ab_stop_done", done_cnt, 32'd1);
        i2c_start();
        write_byte(8'hA0, acks[0]);
        write_byte(8'h00, acks[1]);
        write_byte(8'h30, acks[2]);
        for (int unsigned i = 0; i < 3; i++) bit_xfer(1'b1, a);
        i2c_start();
        write_byte(8'hA1, acks[3]);
        chk("ab_acks", {28'h0, acks}, 32'h0);
        read_byte(d, 1'b1);
        chk("ab_rd", {24'h0, d}, 32'hCF);
        i2c_stop();
        tick(8);
        chk("ab_start_nowr", wr_a.size(), 32'd0);

        // Read with no pointer phase in this transaction is refused
        i2c_start();
        write_byte(8'hA1, a);
        chk("np_nack", {31'h0, a}, 32'h1);
        i2c_stop();
        tick(8);
        chk("np_ptr_kept", {16'h0, reg_addr}, 32'h0030);

        // Reset during the device-address ACK
        clear_logs();
        i2c_start();
        for (int unsigned i = 0; i < 8; i++) bit_xfer(i == 0 ? 1'b1 : (i == 2 ? 1'b1 : 1'b0), a);
        tick(Q); m_sda = 1'b1;
        tick(Q); iic_scl = 1'b1;
        tick(Q);
        chk("rs_ack_low", {31'h0, sda_line}, 32'h0);
        mon_en = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("rs_release", {31'h0, sda_line}, 32'h1);
        tick(3);
        rst = 1'b0;
        tick(Q); iic_scl = 1'b0;
        tick(4);
        mon_en = 1'b1;
        chk("rs_busy", {31'h0, iic_busy}, 32'h0);
        chk("rs_addr", {16'h0, reg_addr}, 32'h0);
        i2c_stop();
        tick(8);
        chk("rs_done", done_cnt, 32'd0);

        // 8-bit pointer wrap on the second target
        clear_logs();
        i2c_start();
        write_byte(8'hA4, acks[0]);
        write_byte(8'hFF, acks[1]);
        write_byte(8'h77, acks[2]);
        write_byte(8'h88, acks[3]);
        i2c_stop();
        tick(8);
        chk("wr8_acks", {28'h0, acks}, 32'h0);
        chk_wr("wr8_0", 1'b1, 0, 16'h00FF, 8'h77);
        chk_wr("wr8_1", 1'b1, 1, 16'h0000, 8'h88);
        chk("wr8_ptr", {16'h0, reg_addr2}, 32'h0001);
        chk("wr8_done", done_cnt2, 32'd1);
        chk("wr8_other_quiet", wr_a.size() + done_cnt, 32'd0);

        chk("timing_viol", viol, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
